// File: rtl/sta_ldque_chk_arb.sv
// Purpose : age-ordered arbiter from NUM_STA store-address pipes into the load-queue violation-check port.
// Latency : 2 cycles from enqueue to o_chk_vld (FIFO write, then head -> output register); 1 check/cycle sustained.
// Backpr. : o_req_rdy[k] low while FIFO k is full; output register holds stable while o_chk_vld && !i_chk_rdy.
//
// Ports:
//   clk, rst (async, active-low)
//   i_req_vld/sqIdx/vaddr/store_vec, o_req_rdy : per-pipe request posting (flattened, pipe k at slice k)
//   i_squash_vld/sqIdx                        : kills every entry not older than the squash point
//   o_chk_vld/sqIdx/vaddr/store_vec, i_chk_rdy: load-queue check port
//   o_empty                                   : no entry anywhere in the block
// Build options:
//   STA_CHK_PERF_EN : adds o_perf_issue / o_perf_stall / o_perf_full saturating counters
//   ASSERT          : enables the request-while-full protocol assertion
module sta_ldque_chk_arb #(
  parameter int NUM_STA    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int SQ_DEPTH   = 32,
  parameter int XLEN       = 64,
  localparam int SQW       = $clog2(SQ_DEPTH) + 1,
  localparam int BW        = XLEN / 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_STA-1:0]     i_req_vld,
  input  logic [NUM_STA*SQW-1:0] i_req_sqIdx,
  input  logic [NUM_STA*XLEN-1:0] i_req_vaddr,
  input  logic [NUM_STA*BW-1:0]  i_req_store_vec,
  output logic [NUM_STA-1:0]     o_req_rdy,
  input  logic                   i_squash_vld,
  input  logic [SQW-1:0]         i_squash_sqIdx,
  output logic                   o_chk_vld,
  output logic [SQW-1:0]         o_chk_sqIdx,
  output logic [XLEN-1:0]        o_chk_vaddr,
  output logic [BW-1:0]          o_chk_store_vec,
  input  logic                   i_chk_rdy,
  output logic                   o_empty
`ifdef STA_CHK_PERF_EN
  ,
  output logic [31:0]            o_perf_issue,
  output logic [31:0]            o_perf_stall,
  output logic [31:0]            o_perf_full
`endif
);

  localparam int IW = SQW - 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = (NUM_STA > 1) ? $clog2(NUM_STA) : 1;

  // Store-queue age compare; the flipped bit resolves wrap-around.
  function automatic logic older(input logic [SQW-1:0] a, input logic [SQW-1:0] b);
    if (a[IW] == b[IW]) return a[IW-1:0] < b[IW-1:0];
    else                return a[IW-1:0] > b[IW-1:0];
  endfunction

  logic [SQW-1:0]  mem_sq  [NUM_STA][FIFO_DEPTH];
  logic [XLEN-1:0] mem_va  [NUM_STA][FIFO_DEPTH];
  logic [BW-1:0]   mem_vec [NUM_STA][FIFO_DEPTH];
  logic [PW-1:0]   hd_q    [NUM_STA];
  logic [CW-1:0]   cnt_q   [NUM_STA];

  logic            out_vld_q;
  logic [SQW-1:0]  out_sq_q;
  logic [XLEN-1:0] out_va_q;
  logic [BW-1:0]   out_vec_q;

  logic [CW-1:0]   keep    [NUM_STA];
  logic [SQW-1:0]  head_sq [NUM_STA];
  logic [PW-1:0]   wslot   [NUM_STA];
  logic [NUM_STA-1:0] push, pop;
  logic [SW-1:0]   sel;
  logic            sel_vld;
  logic            out_kill;
  logic            fire;
  logic            any_cnt;

  always_comb begin
    o_req_rdy = '0;
    push      = '0;
    pop       = '0;
    sel       = '0;
    sel_vld   = 1'b0;
    any_cnt   = 1'b0;
    for (int k = 0; k < NUM_STA; k++) begin
      o_req_rdy[k] = (cnt_q[k] != CW'(FIFO_DEPTH));
      any_cnt      = any_cnt | (cnt_q[k] != '0);
      head_sq[k]   = mem_sq[k][hd_q[k]];
      // Entries enqueue in age order, so killed entries are a contiguous
      // tail: the surviving length is the offset of the first killed slot.
      keep[k] = cnt_q[k];
      if (i_squash_vld) begin
        for (int i = FIFO_DEPTH - 1; i >= 0; i--) begin
          if ((CW'(i) < cnt_q[k]) &&
              !older(mem_sq[k][hd_q[k] + PW'(i)], i_squash_sqIdx))
            keep[k] = CW'(i);
        end
      end
      push[k] = i_req_vld[k] && o_req_rdy[k] &&
                !(i_squash_vld && !older(i_req_sqIdx[k*SQW +: SQW], i_squash_sqIdx));
      wslot[k] = hd_q[k] + keep[k][PW-1:0];
    end
    // Oldest surviving head wins; strict compare keeps ties on the lowest pipe.
    for (int k = 0; k < NUM_STA; k++) begin
      if ((keep[k] != '0) && (!sel_vld || older(head_sq[k], head_sq[sel]))) begin
        sel_vld = 1'b1;
        sel     = SW'(k);
      end
    end
    out_kill = out_vld_q && i_squash_vld && !older(out_sq_q, i_squash_sqIdx);
    // A killed output slot is free for refill in the same cycle.
    fire = !out_vld_q || i_chk_rdy || out_kill;
    if (fire && sel_vld) pop[sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_STA; k++) begin
        hd_q[k]  <= '0;
        cnt_q[k] <= '0;
      end
      out_vld_q <= 1'b0;
      out_sq_q  <= '0;
      out_va_q  <= '0;
      out_vec_q <= '0;
    end else begin
      for (int k = 0; k < NUM_STA; k++) begin
        cnt_q[k] <= keep[k] - CW'(pop[k]) + CW'(push[k]);
        hd_q[k]  <= hd_q[k] + PW'(pop[k]);
      end
      if (fire) begin
        out_vld_q <= sel_vld;
        if (sel_vld) begin
          out_sq_q  <= mem_sq[sel][hd_q[sel]];
          out_va_q  <= mem_va[sel][hd_q[sel]];
          out_vec_q <= mem_vec[sel][hd_q[sel]];
        end
      end
    end
  end

  // Payload storage needs no reset: validity lives in the counts.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_STA; k++) begin
      if (push[k]) begin
        mem_sq[k][wslot[k]]  <= i_req_sqIdx[k*SQW +: SQW];
        mem_va[k][wslot[k]]  <= i_req_vaddr[k*XLEN +: XLEN];
        mem_vec[k][wslot[k]] <= i_req_store_vec[k*BW +: BW];
      end
    end
  end

  assign o_chk_vld       = out_vld_q;
  assign o_chk_sqIdx     = out_sq_q;
  assign o_chk_vaddr     = out_va_q;
  assign o_chk_store_vec = out_vec_q;
  assign o_empty         = !any_cnt && !out_vld_q;

`ifdef STA_CHK_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_perf_issue <= '0;
      o_perf_stall <= '0;
      o_perf_full  <= '0;
    end else begin
      if (out_vld_q && i_chk_rdy && (o_perf_issue != '1)) o_perf_issue <= o_perf_issue + 32'd1;
      if (out_vld_q && !i_chk_rdy && (o_perf_stall != '1)) o_perf_stall <= o_perf_stall + 32'd1;
      if (!(&o_req_rdy) && (o_perf_full != '1)) o_perf_full <= o_perf_full + 32'd1;
    end
  end
`endif

`ifdef ASSERT
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_STA; k++)
        assert (!(i_req_vld[k] && !o_req_rdy[k]));
    end
  end
`endif

endmodule
